// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx: 8N1 UART receiver, counterpart of the team UART transmitter.
// The serial line is synchronised and watched for a falling edge. Each bit is
// sampled near its middle using a baud counter that shares the transmitter's
// bit-timing parameters.
//
// Parameters:
//   D            clock cycles per bit (even, >= 4)
//   L            baud counter width (2**L > D)
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-low reset
//   i_rx         serial line, idle high, asynchronous to i_clk
//   o_data       last correctly framed byte, held until the next good frame
//   o_valid      one-cycle pulse when o_data has just been updated
//   o_frame_err  one-cycle pulse when the stop bit is sampled low
//   o_busy       high from start-edge detection until the return to IDLE
// ----------------------------------------------------------------------------
module uart_rx #(
   parameter int unsigned D = 10,
   parameter int unsigned L = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_busy
);

   localparam logic [L-1:0] HALF_CNT = L'(D/2 - 1);
   localparam logic [L-1:0] FULL_CNT = L'(D - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t       r_state;
   logic         r_sync1;
   logic         r_rx_s;
   logic         r_rx_s_d;
   logic [L-1:0] r_cnt;
   logic [2:0]   r_idx;
   logic [7:0]   r_shift;
   logic [7:0]   r_data;
   logic         r_valid;
   logic         r_frame_err;
   logic         r_busy;

   logic         w_start_edge;

   // Two-flop synchroniser plus one history flop; all preset to idle-high.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_sync1  <= 1'b1;
         r_rx_s   <= 1'b1;
         r_rx_s_d <= 1'b1;
      end else begin
         r_sync1  <= i_rx;
         r_rx_s   <= r_sync1;
         r_rx_s_d <= r_rx_s;
      end
   end

   // A held-low line never re-triggers: a high sample must precede the low one.
   assign w_start_edge = r_rx_s_d & ~r_rx_s;

   // Receive FSM with registered strobes.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cnt  <= '0;
               r_busy <= 1'b0;
               if (w_start_edge) begin
                  r_state <= START;
                  r_busy  <= 1'b1;
               end
            end

            // Mid start bit: a high line here was only a glitch.
            START: begin
               if (r_cnt == HALF_CNT) begin
                  r_cnt <= '0;
                  if (r_rx_s) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= DATA;
                     r_idx   <= '0;
                  end
               end else begin
                  r_cnt <= r_cnt + L'(1);
               end
            end

            // One full bit period after the previous sample, LSB first.
            DATA: begin
               if (r_cnt == FULL_CNT) begin
                  r_cnt          <= '0;
                  r_shift[r_idx] <= r_rx_s;
                  if (r_idx == 3'd7) begin
                     r_state <= STOP;
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + L'(1);
               end
            end

            // Return to IDLE at mid stop bit so a back-to-back start is caught.
            STOP: begin
               if (r_cnt == FULL_CNT) begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  if (r_rx_s) begin
                     r_data  <= r_shift;
                     r_valid <= 1'b1;
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + L'(1);
               end
            end

            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_data      = r_data;
   assign o_valid     = r_valid;
   assign o_frame_err = r_frame_err;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx: directed bench for uart_rx. A table of frames is driven through
// a behavioural 8N1 transmitter; hand-written sequences cover latency,
// back-to-back frames, glitches, reset mid-frame and line break.
// ----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int unsigned D = 10;
   localparam int unsigned L = 4;

   logic       i_clk;
   logic       i_rst;
   logic       i_rx;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_frame_err;
   logic       o_busy;

   uart_rx #(.D(D), .L(L)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_rx        (i_rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_frame_err (o_frame_err),
      .o_busy      (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   // Strobe monitor state, updated on the falling edge.
   int         n_valid   = 0;
   int         n_err     = 0;
   int         last_vcyc = 0;
   int         prev_vcyc = 0;
   logic [7:0] last_vdata = 8'h00;
   logic [7:0] prev_vdata = 8'h00;
   logic       prev_strobe = 1'b0;
   logic       busy_seen   = 1'b0;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_v;
      int         exp_e;
      logic [7:0] exp_data;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      if (o_busy) busy_seen = 1'b1;
      if (o_valid || o_frame_err) begin
         check("strobe_exclusive", int'(o_valid & o_frame_err), 0);
         check("strobe_not_back_to_back", int'(prev_strobe), 0);
      end
      if (o_valid) begin
         n_valid++;
         prev_vcyc  = last_vcyc;
         prev_vdata = last_vdata;
         last_vcyc  = cyc;
         last_vdata = o_data;
      end
      if (o_frame_err) n_err++;
      prev_strobe = o_valid | o_frame_err;
   end

   // Called at a falling edge; leaves the line high at a falling edge.
   task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
      t0   = cyc;
      i_rx = 1'b0;
      repeat (D) @(negedge i_clk);
      for (int i = 0; i < 8; i++) begin
         i_rx = b[i];
         repeat (D) @(negedge i_clk);
      end
      i_rx = stop;
      repeat (D) @(negedge i_clk);
      i_rx = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   initial begin
      int t0;
      int v0;
      int e0;

      tbl[0] = '{data: 8'h41, stop: 1'b1, exp_v: 1, exp_e: 0, exp_data: 8'h41};
      tbl[1] = '{data: 8'hA5, stop: 1'b0, exp_v: 0, exp_e: 1, exp_data: 8'h41};
      tbl[2] = '{data: 8'h00, stop: 1'b1, exp_v: 1, exp_e: 0, exp_data: 8'h00};
      tbl[3] = '{data: 8'hFF, stop: 1'b1, exp_v: 1, exp_e: 0, exp_data: 8'hFF};
      tbl[4] = '{data: 8'h3C, stop: 1'b1, exp_v: 1, exp_e: 0, exp_data: 8'h3C};
      tbl[5] = '{data: 8'h12, stop: 1'b0, exp_v: 0, exp_e: 1, exp_data: 8'h3C};
      tbl[6] = '{data: 8'h80, stop: 1'b1, exp_v: 1, exp_e: 0, exp_data: 8'h80};
      tbl[7] = '{data: 8'h01, stop: 1'b1, exp_v: 1, exp_e: 0, exp_data: 8'h01};

      // Reset state
      i_rst = 1'b0;
      i_rx  = 1'b1;
      repeat (3) @(negedge i_clk);
      check("reset_data",  int'(o_data), 0);
      check("reset_valid", int'(o_valid), 0);
      check("reset_err",   int'(o_frame_err), 0);
      check("reset_busy",  int'(o_busy), 0);
      i_rst = 1'b1;
      idle(5);

      // Table of single frames with a short idle gap after each
      for (int i = 0; i < 8; i++) begin
         v0 = n_valid;
         e0 = n_err;
         send_frame(tbl[i].data, tbl[i].stop, t0);
         idle(2 * D);
         check($sformatf("vec%0d_valid_count", i), n_valid - v0, tbl[i].exp_v);
         check($sformatf("vec%0d_err_count", i),   n_err - e0,   tbl[i].exp_e);
         check($sformatf("vec%0d_data", i),        int'(o_data), int'(tbl[i].exp_data));
         check($sformatf("vec%0d_busy_idle", i),   int'(o_busy), 0);
         // Start edge before edge 0; o_valid high after edge 2 + D/2 + 9*D.
         if (i == 0) check("vec0_latency", last_vcyc - t0, 1 + 2 + D/2 + 9*D);
      end

      // Back-to-back 8'h00 then 8'hFF with no idle gap
      v0 = n_valid;
      send_frame(8'h00, 1'b1, t0);
      send_frame(8'hFF, 1'b1, t0);
      idle(2 * D);
      check("b2b_valid_count", n_valid - v0, 2);
      check("b2b_first_data",  int'(prev_vdata), 8'h00);
      check("b2b_second_data", int'(last_vdata), 8'hFF);
      check("b2b_spacing",     last_vcyc - prev_vcyc, 10 * D);

      // Glitch shorter than half a bit
      v0 = n_valid;
      e0 = n_err;
      busy_seen = 1'b0;
      i_rx = 1'b0;
      idle(3);
      i_rx = 1'b1;
      idle(2 * D);
      check("glitch_busy_seen", int'(busy_seen), 1);
      check("glitch_busy_idle", int'(o_busy), 0);
      check("glitch_valid",     n_valid - v0, 0);
      check("glitch_err",       n_err - e0, 0);

      // Reset during data bit 4 of 8'h3C
      v0 = n_valid;
      e0 = n_err;
      i_rx = 1'b0;
      idle(D);
      for (int i = 0; i < 4; i++) begin
         i_rx = 1'(8'h3C >> i);
         idle(D);
      end
      i_rx = 1'b1;
      idle(D / 2);
      check("pre_abort_busy", int'(o_busy), 1);
      i_rst = 1'b0;
      #1;
      check("abort_busy", int'(o_busy), 0);
      check("abort_data", int'(o_data), 0);
      @(negedge i_clk);
      idle(3);
      i_rst = 1'b1;
      idle(2 * D);
      check("abort_no_valid", n_valid - v0, 0);
      check("abort_no_err",   n_err - e0, 0);
      check("abort_busy_after_release", int'(o_busy), 0);
      send_frame(8'h3C, 1'b1, t0);
      idle(2 * D);
      check("post_abort_valid", n_valid - v0, 1);
      check("post_abort_data",  int'(o_data), 8'h3C);

      // Break: line low for 30 bit times
      v0 = n_valid;
      e0 = n_err;
      i_rx = 1'b0;
      idle(30 * D);
      check("break_busy_while_low", int'(o_busy), 0);
      i_rx = 1'b1;
      idle(2 * D);
      check("break_err_count",   n_err - e0, 1);
      check("break_valid_count", n_valid - v0, 0);
      check("break_data_held",   int'(o_data), 8'h3C);
      send_frame(8'h55, 1'b1, t0);
      idle(2 * D);
      check("after_break_valid", n_valid - v0, 1);
      check("after_break_err",   n_err - e0, 1);
      check("after_break_data",  int'(o_data), 8'h55);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
